// File: rtl/rgb_frame_drain_pkg.sv
// Shared definitions for the RGB frame drain stage.
//   - Frame geometry (10x10), pixel/address/sum widths.
//   - Channel field positions inside the packed {R,G,B} pixel.
//   - Controller state encoding.
//   - Grey conversion helper used on the drain path.
package rgb_frame_drain_pkg;

  localparam int FRAME_W = 10;
  localparam int N_PIX   = FRAME_W * FRAME_W;
  localparam int PIX_W   = 12;
  localparam int CH_W    = 4;
  localparam int ADDR_W  = $clog2(N_PIX);
  // Wide enough for 15 * N_PIX, so the sums never wrap.
  localparam int SUM_W   = CH_W + $clog2(N_PIX);

  localparam int R_LSB = 8;
  localparam int G_LSB = 4;
  localparam int B_LSB = 0;

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // y = (R + 2G + B) >> 2 at 6 bits (max 60 fits), replicated into all channels.
  function automatic logic [PIX_W-1:0] to_grey(input logic [PIX_W-1:0] p);
    logic [5:0] y6;
    y6 = {2'b00, p[R_LSB +: CH_W]}
       + {1'b0, p[G_LSB +: CH_W], 1'b0}
       + {2'b00, p[B_LSB +: CH_W]};
    return {3{y6[5:2]}};
  endfunction

endpackage

// File: rtl/rgb_frame_drain_if.sv
// Bundle of all non-clock signals of the frame drain stage.
//   Upstream : in_valid, in_addr, in_data (no backpressure)
//   Control  : mode (0 RGB, 1 grey), clear (abort / restart capture)
//   Stream   : out_valid, out_ready, out_data, out_last
//   Status   : sum_r/g/b, stats_valid, frame_done, addr_err
// master = producer/consumer environment, slave = the drain stage.
interface rgb_frame_drain_if;
  import rgb_frame_drain_pkg::*;

  logic              in_valid;
  logic [ADDR_W-1:0] in_addr;
  logic [PIX_W-1:0]  in_data;
  logic              mode;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [PIX_W-1:0]  out_data;
  logic              out_last;
  logic [SUM_W-1:0]  sum_r;
  logic [SUM_W-1:0]  sum_g;
  logic [SUM_W-1:0]  sum_b;
  logic              stats_valid;
  logic              frame_done;
  logic              addr_err;

  modport master (
    output in_valid, in_addr, in_data, mode, clear, out_ready,
    input  out_valid, out_data, out_last, sum_r, sum_g, sum_b,
           stats_valid, frame_done, addr_err
  );

  modport slave (
    input  in_valid, in_addr, in_data, mode, clear, out_ready,
    output out_valid, out_data, out_last, sum_r, sum_g, sum_b,
           stats_valid, frame_done, addr_err
  );

endinterface

// File: rtl/rgb_frame_drain_pix_frame_ram.sv
// Frame buffer: N_PIX x PIX_W, one write port, one registered read port.
// Capture and drain never overlap, so read-during-write is don't-care.
//   clk        : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_en_i    : read strobe, data appears on rd_data_o next cycle
//   rd_addr_i  : read address
//   rd_data_o  : registered read data
module rgb_frame_drain_pix_frame_ram
  import rgb_frame_drain_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [PIX_W-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [PIX_W-1:0]  rd_data_o
);

  logic [PIX_W-1:0] mem_q [N_PIX];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_o <= mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/rgb_frame_drain.sv
// Captures one demosaiced 10x10 RGB frame into a buffer while summing each
// channel, then streams the frame in raster order over valid/ready, either
// as RGB or as replicated grey.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : rgb_frame_drain_if.slave (upstream pixels, control, output
//          stream and status; see the interface file)
module rgb_frame_drain
  import rgb_frame_drain_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  rgb_frame_drain_if.slave bus
);

  state_e            state_q;
  logic [ADDR_W-1:0] wr_cnt_q;
  logic [ADDR_W-1:0] wr_cnt_d;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [SUM_W-1:0]  sum_q [3];
  logic [SUM_W-1:0]  sum_d [3];
  logic              stats_valid_q;
  logic              frame_done_q;
  logic              addr_err_q;
  logic              mode_q;

  // Drain pipeline: RAM read in flight -> skid register -> output register.
  logic              pend_q;
  logic              pend_last_q;
  logic              skid_valid_q;
  logic              skid_last_q;
  logic [PIX_W-1:0]  skid_data_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic [PIX_W-1:0]  out_data_q;

  logic [PIX_W-1:0]  ram_rd_data;
  logic [PIX_W-1:0]  fill_data;
  logic              in_range;
  logic              wr_en;
  logic              last_wr;
  logic              pop;
  logic              issue;
  logic [1:0]        occ;

  assign in_range = bus.in_addr < ADDR_W'(N_PIX);
  assign wr_en    = (state_q == ST_CAPTURE) && bus.in_valid && !bus.clear && in_range;
  assign wr_cnt_d = wr_cnt_q + 1'b1;
  assign last_wr  = wr_en && (wr_cnt_d == ADDR_W'(N_PIX));

  for (genvar gi = 0; gi < 3; gi++) begin : g_sum
    localparam int LSB = (gi == 0) ? R_LSB : (gi == 1) ? G_LSB : B_LSB;
    assign sum_d[gi] = sum_q[gi] + SUM_W'(bus.in_data[LSB +: CH_W]);
  end

  // Occupancy counts the output register, the skid register and the read in
  // flight. A new read is issued only if it is guaranteed a slot when it
  // lands, which keeps one read per cycle flowing when the sink never stalls.
  assign pop   = out_valid_q && bus.out_ready;
  assign occ   = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(pend_q);
  assign issue = (state_q == ST_DRAIN) && !bus.clear
              && (rd_addr_q < ADDR_W'(N_PIX))
              && ((occ - 2'(pop)) < 2'd2);

  assign fill_data = mode_q ? to_grey(ram_rd_data) : ram_rd_data;

  rgb_frame_drain_pix_frame_ram u_pix_frame_ram (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (bus.in_addr),
    .wr_data_i (bus.in_data),
    .rd_en_i   (issue),
    .rd_addr_i (rd_addr_q),
    .rd_data_o (ram_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_CAPTURE;
      wr_cnt_q      <= '0;
      rd_addr_q     <= '0;
      for (int i = 0; i < 3; i++) sum_q[i] <= '0;
      stats_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      addr_err_q    <= 1'b0;
      mode_q        <= 1'b0;
      pend_q        <= 1'b0;
      pend_last_q   <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_last_q   <= 1'b0;
      skid_data_q   <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_data_q    <= '0;
    end else if (bus.clear) begin
      // Buffer contents are left as-is; the next capture overwrites them.
      state_q       <= ST_CAPTURE;
      wr_cnt_q      <= '0;
      rd_addr_q     <= '0;
      for (int i = 0; i < 3; i++) sum_q[i] <= '0;
      stats_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      addr_err_q    <= 1'b0;
      pend_q        <= 1'b0;
      skid_valid_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
    end else begin
      pend_q      <= issue;
      pend_last_q <= (rd_addr_q == ADDR_W'(N_PIX - 1));
      if (issue) begin
        rd_addr_q <= rd_addr_q + 1'b1;
      end

      case (state_q)
        ST_CAPTURE: begin
          if (bus.in_valid && !in_range) begin
            addr_err_q <= 1'b1;
          end
          if (wr_en) begin
            wr_cnt_q <= wr_cnt_d;
            for (int i = 0; i < 3; i++) sum_q[i] <= sum_d[i];
            if (last_wr) begin
              stats_valid_q <= 1'b1;
              mode_q        <= bus.mode;
              state_q       <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && out_last_q) begin
            frame_done_q <= 1'b1;
            state_q      <= ST_DONE;
          end
        end
        default: begin
        end
      endcase

      // Output register refills from skid first (older data), else straight
      // from the RAM; a stalled output pushes arriving RAM data into skid.
      if (!out_valid_q || pop) begin
        if (skid_valid_q) begin
          out_valid_q  <= 1'b1;
          out_data_q   <= skid_data_q;
          out_last_q   <= skid_last_q;
          skid_valid_q <= pend_q;
          if (pend_q) begin
            skid_data_q <= fill_data;
            skid_last_q <= pend_last_q;
          end
        end else if (pend_q) begin
          out_valid_q <= 1'b1;
          out_data_q  <= fill_data;
          out_last_q  <= pend_last_q;
        end else begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      end else if (pend_q) begin
        skid_valid_q <= 1'b1;
        skid_data_q  <= fill_data;
        skid_last_q  <= pend_last_q;
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_last    = out_last_q;
  assign bus.sum_r       = sum_q[0];
  assign bus.sum_g       = sum_q[1];
  assign bus.sum_b       = sum_q[2];
  assign bus.stats_valid = stats_valid_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.addr_err    = addr_err_q;

endmodule

// File: tb/tb_rgb_frame_drain.sv
// Directed bench for rgb_frame_drain: a table of whole-frame cases plus
// hand-written sequences for address errors, async reset and mid-drain abort.
module tb_rgb_frame_drain;
  import rgb_frame_drain_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rgb_frame_drain_if bus ();

  rgb_frame_drain dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        ramp;      // 1: pixel k = {k[3:0], ~k[3:0], 5}
    logic [11:0] fill;      // constant pixel when ramp = 0
    logic        md;        // mode for the frame
    logic        stall;     // out_ready pattern 1,0,0,...
    logic [11:0] exp_flat;  // expected beat when ramp = 0
    int          exp_r;
    int          exp_g;
    int          exp_b;
  } vec_t;

  vec_t vecs [5];
  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] ramp_pix(input int k);
    logic [3:0] n;
    n = 4'(k);
    return {n, ~n, 4'h5};
  endfunction

  task automatic do_clear();
    @(negedge clk);
    bus.clear     = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  // Writes addresses 0..99; returns at the negedge of the first drain cycle
  // with the upstream tail (addr 99, junk data, flipped mode) being driven.
  task automatic capture(input logic ramp, input logic [11:0] fill, input logic md);
    for (int k = 0; k < N_PIX; k++) begin
      @(negedge clk);
      if (k == N_PIX - 1) check("stats_before_last_write", int'(bus.stats_valid), 0);
      bus.in_valid = 1'b1;
      bus.in_addr  = 7'(k);
      bus.in_data  = ramp ? ramp_pix(k) : fill;
      bus.mode     = md;
    end
    @(negedge clk);
    check("stats_valid_after_last_write", int'(bus.stats_valid), 1);
    bus.in_addr = 7'(N_PIX - 1);
    bus.in_data = 12'h0A0;
    bus.mode    = ~md;
  endtask

  task automatic drain(input logic ramp, input logic [11:0] flat, input logic stall,
                       input int abort_at);
    int beat, cyc, first, lastc;
    logic held, rdy;
    logic [11:0] held_d, want;
    beat = 0; cyc = 0; first = -1; lastc = 0; held = 1'b0; held_d = '0;
    while (beat < N_PIX && cyc < 700) begin
      if (cyc > 0) @(negedge clk);
      bus.in_valid = (cyc < 50);
      rdy = stall ? (cyc % 3 == 0) : 1'b1;
      if (held) begin
        check("stall_valid_held", int'(bus.out_valid), 1);
        check("stall_data_stable", int'(bus.out_data), int'(held_d));
        held = 1'b0;
      end
      if (bus.out_valid && first < 0) begin
        first = cyc;
        check("first_valid_within_2", int'(cyc <= 2), 1);
      end
      if (bus.out_valid && beat == abort_at) begin
        bus.clear     = 1'b1;
        bus.out_ready = 1'b0;
        break;
      end
      if (bus.out_valid) begin
        if (rdy) begin
          want = ramp ? ramp_pix(beat) : flat;
          check($sformatf("beat%0d_data", beat), int'(bus.out_data), int'(want));
          check($sformatf("beat%0d_last", beat), int'(bus.out_last), int'(beat == N_PIX - 1));
          lastc = cyc;
          beat++;
        end else begin
          held   = 1'b1;
          held_d = bus.out_data;
        end
      end
      bus.out_ready = rdy;
      cyc++;
    end
    if (abort_at >= 0) return;
    check("beat_count", beat, N_PIX);
    if (!stall) check("no_bubbles", lastc - first, N_PIX - 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("frame_done_after_last", int'(bus.frame_done), 1);
    check("valid_low_after_last", int'(bus.out_valid), 0);
    repeat (3) @(negedge clk);
    check("done_frame_done_held", int'(bus.frame_done), 1);
    check("done_stats_held", int'(bus.stats_valid), 1);
    check("done_no_valid", int'(bus.out_valid), 0);
    $display("frame drained: beats=%0d cycles=%0d", beat, cyc);
  endtask

  task automatic check_sums(input string tag, input int r, input int g, input int b);
    check({tag, "_sum_r"}, int'(bus.sum_r), r);
    check({tag, "_sum_g"}, int'(bus.sum_g), g);
    check({tag, "_sum_b"}, int'(bus.sum_b), b);
  endtask

  initial begin
    // Ramp sums: low nibbles of 0..99 total 6*120 + (0+1+2+3) = 726,
    // inverted nibbles 1500 - 726 = 774, blue 5*100 = 500.
    vecs[0] = '{1'b1, 12'h000, 1'b0, 1'b0, 12'h000,  726,  774,  500};
    vecs[1] = '{1'b0, 12'hF3A, 1'b0, 1'b0, 12'hF3A, 1500,  300, 1000};
    vecs[2] = '{1'b0, 12'hF0F, 1'b1, 1'b0, 12'h777, 1500,    0, 1500};
    vecs[3] = '{1'b0, 12'hFFF, 1'b1, 1'b0, 12'hFFF, 1500, 1500, 1500};
    vecs[4] = '{1'b1, 12'h000, 1'b0, 1'b1, 12'h000,  726,  774,  500};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_data = '0;
    bus.mode = 1'b0; bus.clear = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_stats_valid", int'(bus.stats_valid), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    check("rst_addr_err", int'(bus.addr_err), 0);
    check_sums("rst", 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      do_clear();
      capture(vecs[i].ramp, vecs[i].fill, vecs[i].md);
      check_sums($sformatf("vec%0d", i), vecs[i].exp_r, vecs[i].exp_g, vecs[i].exp_b);
      drain(vecs[i].ramp, vecs[i].exp_flat, vecs[i].stall, -1);
      check_sums($sformatf("vec%0d_done", i), vecs[i].exp_r, vecs[i].exp_g, vecs[i].exp_b);
    end

    // Dropped writes: clear with a simultaneous write, then an out-of-range
    // address; neither may count toward the 100 writes nor the sums.
    @(negedge clk);
    bus.clear = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_addr = 7'd0; bus.in_data = 12'hFFF;
    @(negedge clk);
    bus.clear = 1'b0; bus.in_addr = 7'd100; bus.in_data = 12'hFFF;
    @(negedge clk);
    check("addr_err_set", int'(bus.addr_err), 1);
    bus.in_valid = 1'b0;
    capture(1'b0, 12'h111, 1'b0);
    check_sums("err", 100, 100, 100);
    drain(1'b0, 12'h111, 1'b0, -1);
    check("addr_err_sticky", int'(bus.addr_err), 1);
    do_clear();
    check("addr_err_cleared", int'(bus.addr_err), 0);

    // Asynchronous reset in the middle of a drain.
    capture(1'b1, 12'h000, 1'b0);
    bus.out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("pre_rst_valid", int'(bus.out_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", int'(bus.out_valid), 0);
    check("async_rst_stats", int'(bus.stats_valid), 0);
    check("async_rst_sum_r", int'(bus.sum_r), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    // Abort at beat 40, then a new grey frame from pixel 0.
    // 12'h3C5 -> (3 + 24 + 5) >> 2 = 8.
    do_clear();
    capture(1'b1, 12'h000, 1'b0);
    drain(1'b1, 12'h000, 1'b0, 40);
    @(negedge clk);
    check("abort_out_valid", int'(bus.out_valid), 0);
    check("abort_stats_valid", int'(bus.stats_valid), 0);
    check("abort_frame_done", int'(bus.frame_done), 0);
    check_sums("abort", 0, 0, 0);
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    capture(1'b0, 12'h3C5, 1'b1);
    check_sums("refill", 300, 1200, 500);
    drain(1'b0, 12'h888, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
